// File: rtl/connect4_pkg.sv
// Shared Connect-4 geometry, colour encoding and scan directions.
// Also holds the cell-index mapping and a saturating 4-bit score increment.
package connect4_pkg;

    localparam int COLS  = 7;
    localparam int ROWS  = 6;
    localparam int CELLS = 42;

    localparam logic YELLOW = 1'b0;
    localparam logic RED    = 1'b1;

    typedef enum logic [1:0] {
        DIR_R  = 2'd0,
        DIR_U  = 2'd1,
        DIR_UR = 2'd2,
        DIR_DR = 2'd3
    } dir_e;

    function automatic logic [5:0] cell_idx(input int col, input int row);
        return 6'(col * ROWS + row);
    endfunction

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'd15) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/c4_line_check.sv
// Combinational check of the four lines of four that start at one anchor cell.
// A line only counts if its far end is on the board and all four cells share one colour.
module c4_line_check
    import connect4_pkg::*;
(
    input  logic [CELLS-1:0] occupied,
    input  logic [CELLS-1:0] color,
    input  logic [2:0]       anchor_col,
    input  logic [2:0]       anchor_row,
    output logic             hit_red,
    output logic             hit_yellow
);

    int         dc;
    int         dr;
    int         end_c;
    int         end_r;
    logic       in_bounds;
    logic       all_occ;
    logic       all_red;
    logic       all_yel;
    logic [5:0] idx;

    // Evaluate right, up, up-right and down-right lines from the anchor.
    always_comb begin
        hit_red    = 1'b0;
        hit_yellow = 1'b0;
        dc         = 0;
        dr         = 0;
        end_c      = 0;
        end_r      = 0;
        in_bounds  = 1'b0;
        all_occ    = 1'b0;
        all_red    = 1'b0;
        all_yel    = 1'b0;
        idx        = 6'd0;
        for (int d = 0; d < 4; d++) begin
            case (dir_e'(d))
                DIR_R:   begin dc = 1; dr = 0;  end
                DIR_U:   begin dc = 0; dr = 1;  end
                DIR_UR:  begin dc = 1; dr = 1;  end
                DIR_DR:  begin dc = 1; dr = -1; end
                default: begin dc = 0; dr = 0;  end
            endcase
            end_c     = int'(anchor_col) + 3 * dc;
            end_r     = int'(anchor_row) + 3 * dr;
            in_bounds = (end_c >= 0) && (end_c < COLS) && (end_r >= 0) && (end_r < ROWS);
            all_occ   = in_bounds;
            all_red   = in_bounds;
            all_yel   = in_bounds;
            for (int k = 0; k < 4; k++) begin
                if (in_bounds) begin
                    idx     = cell_idx(int'(anchor_col) + k * dc, int'(anchor_row) + k * dr);
                    all_occ = all_occ & occupied[idx];
                    all_red = all_red & color[idx];
                    all_yel = all_yel & ~color[idx];
                end else begin
                    idx = 6'd0;
                end
            end
            hit_red    = hit_red | (all_occ & all_red);
            hit_yellow = hit_yellow | (all_occ & all_yel);
        end
    end

endmodule

// File: rtl/connect4_win_detector.sv
// Snapshots the board after each move, scans all 42 anchors one per cycle and
// reports sticky win/draw/game-over flags plus saturating per-colour scores.
module connect4_win_detector
    import connect4_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mover,
    input  logic [CELLS-1:0] occupied,
    input  logic [CELLS-1:0] color,
    input  logic             clear_game,
    input  logic             clear_score,
    output logic             busy,
    output logic             result_valid,
    output logic             red_win,
    output logic             yellow_win,
    output logic             draw,
    output logic             game_over,
    output logic [3:0]       score_red,
    output logic [3:0]       score_yellow
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [2:0]       col_q, col_d;
    logic [2:0]       row_q, row_d;
    logic [CELLS-1:0] snap_occ_q, snap_occ_d;
    logic [CELLS-1:0] snap_color_q, snap_color_d;
    logic             snap_mover_q, snap_mover_d;
    logic             acc_r_q, acc_r_d;
    logic             acc_y_q, acc_y_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic             red_q, red_d;
    logic             yel_q, yel_d;
    logic             draw_q, draw_d;
    logic             over_q, over_d;
    logic [3:0]       score_r_q, score_r_d;
    logic [3:0]       score_y_q, score_y_d;

    logic hit_red_s, hit_yellow_s;
    logic last_anchor_s, publish_s;
    logic fin_r_s, fin_y_s, full_s;
    logic credit_r_s, credit_y_s;

    c4_line_check u_line_check (
        .occupied   (snap_occ_q),
        .color      (snap_color_q),
        .anchor_col (col_q),
        .anchor_row (row_q),
        .hit_red    (hit_red_s),
        .hit_yellow (hit_yellow_s)
    );

    assign last_anchor_s = (col_q == 3'(COLS - 1)) && (row_q == 3'(ROWS - 1));
    assign publish_s     = (state_q == ST_SCAN) && last_anchor_s;
    assign fin_r_s       = acc_r_q | hit_red_s;
    assign fin_y_s       = acc_y_q | hit_yellow_s;
    assign full_s        = &snap_occ_q;
    // When both colours hold a four (possible after a pop) only the mover scores.
    assign credit_r_s    = fin_r_s & (~fin_y_s | (snap_mover_q == RED));
    assign credit_y_s    = fin_y_s & (~fin_r_s | (snap_mover_q == YELLOW));

    // Next-state logic for FSM, anchor counter, snapshot, flags and scores.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        snap_occ_d   = snap_occ_q;
        snap_color_d = snap_color_q;
        snap_mover_d = snap_mover_q;
        acc_r_d      = acc_r_q;
        acc_y_d      = acc_y_q;
        red_d        = red_q;
        yel_d        = yel_q;
        draw_d       = draw_q;
        over_d       = over_q;
        score_r_d    = score_r_q;
        score_y_d    = score_y_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_SCAN;
                    snap_occ_d   = occupied;
                    snap_color_d = color;
                    snap_mover_d = mover;
                    col_d        = 3'd0;
                    row_d        = 3'd0;
                    acc_r_d      = 1'b0;
                    acc_y_d      = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                acc_r_d = fin_r_s;
                acc_y_d = fin_y_s;
                if (last_anchor_s) begin
                    state_d = ST_DONE;
                end else if (row_q == 3'(ROWS - 1)) begin
                    row_d = 3'd0;
                    col_d = col_q + 3'd1;
                end else begin
                    row_d = row_q + 3'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d  = (state_d != ST_IDLE);
        valid_d = publish_s;

        if (clear_game) begin
            red_d  = 1'b0;
            yel_d  = 1'b0;
            draw_d = 1'b0;
            over_d = 1'b0;
        end else if (publish_s) begin
            red_d  = fin_r_s;
            yel_d  = fin_y_s;
            draw_d = full_s & ~fin_r_s & ~fin_y_s;
            over_d = fin_r_s | fin_y_s | full_s;
        end else begin
            red_d = red_q;
        end

        if (clear_score) begin
            score_r_d = 4'd0;
            score_y_d = 4'd0;
        end else if (publish_s) begin
            score_r_d = credit_r_s ? sat_inc4(score_r_q) : score_r_q;
            score_y_d = credit_y_s ? sat_inc4(score_y_q) : score_y_q;
        end else begin
            score_r_d = score_r_q;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            col_q        <= 3'd0;
            row_q        <= 3'd0;
            snap_occ_q   <= '0;
            snap_color_q <= '0;
            snap_mover_q <= 1'b0;
            acc_r_q      <= 1'b0;
            acc_y_q      <= 1'b0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            red_q        <= 1'b0;
            yel_q        <= 1'b0;
            draw_q       <= 1'b0;
            over_q       <= 1'b0;
            score_r_q    <= 4'd0;
            score_y_q    <= 4'd0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            snap_occ_q   <= snap_occ_d;
            snap_color_q <= snap_color_d;
            snap_mover_q <= snap_mover_d;
            acc_r_q      <= acc_r_d;
            acc_y_q      <= acc_y_d;
            busy_q       <= busy_d;
            valid_q      <= valid_d;
            red_q        <= red_d;
            yel_q        <= yel_d;
            draw_q       <= draw_d;
            over_q       <= over_d;
            score_r_q    <= score_r_d;
            score_y_q    <= score_y_d;
        end
    end

    assign busy         = busy_q;
    assign result_valid = valid_q;
    assign red_win      = red_q;
    assign yellow_win   = yel_q;
    assign draw         = draw_q;
    assign game_over    = over_q;
    assign score_red    = score_r_q;
    assign score_yellow = score_y_q;

endmodule

// File: tb/tb_connect4_win_detector.sv
// Directed bench for connect4_win_detector: a board-level reference model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_connect4_win_detector;

    logic        clk = 1'b0;
    logic        reset, start, mover, clear_game, clear_score;
    logic [41:0] occupied, color;
    logic        busy, result_valid, red_win, yellow_win, draw, game_over;
    logic [3:0]  score_red, score_yellow;

    connect4_win_detector dut (
        .clk(clk), .reset(reset), .start(start), .mover(mover),
        .occupied(occupied), .color(color),
        .clear_game(clear_game), .clear_score(clear_score),
        .busy(busy), .result_valid(result_valid),
        .red_win(red_win), .yellow_win(yellow_win), .draw(draw), .game_over(game_over),
        .score_red(score_red), .score_yellow(score_yellow)
    );

    always #5 clk = ~clk;

    // 0 empty, 1 yellow, 2 red; anything off the board reads as empty.
    function automatic int cell_at(input logic [41:0] o, input logic [41:0] c, input int col, input int row);
        if (col < 0 || col > 6 || row < 0 || row > 5) return 0;
        if (!o[6'(col * 6 + row)]) return 0;
        return c[6'(col * 6 + row)] ? 2 : 1;
    endfunction

    function automatic bit has_four(input logic [41:0] o, input logic [41:0] c, input int who);
        int dcs [4] = '{1, 0, 1, 1};
        int drs [4] = '{0, 1, 1, -1};
        for (int col = 0; col < 7; col++)
            for (int row = 0; row < 6; row++)
                for (int d = 0; d < 4; d++) begin
                    bit ok = 1'b1;
                    for (int k = 0; k < 4; k++)
                        if (cell_at(o, c, col + k * dcs[d], row + k * drs[d]) != who) ok = 1'b0;
                    if (ok) return 1'b1;
                end
        return 1'b0;
    endfunction

    // Reference model: result appears 42 edges after acceptance, busy drops at 43.
    logic       m_busy, m_rv, m_red, m_yel, m_draw, m_go, m_mover;
    logic       m_exp_r, m_exp_y, m_full;
    logic [3:0] m_sr, m_sy;
    int         m_cnt;
    wire        m_pub = m_busy && (m_cnt == 42);
    wire        m_cr  = m_exp_r && (!m_exp_y || m_mover);
    wire        m_cy  = m_exp_y && (!m_exp_r || !m_mover);

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0; m_rv <= 1'b0; m_cnt <= 0;
            m_red <= 1'b0; m_yel <= 1'b0; m_draw <= 1'b0; m_go <= 1'b0;
            m_sr <= 4'd0; m_sy <= 4'd0;
            m_exp_r <= 1'b0; m_exp_y <= 1'b0; m_full <= 1'b0; m_mover <= 1'b0;
        end else begin
            if (!m_busy && start) begin
                m_busy  <= 1'b1;
                m_cnt   <= 1;
                m_exp_r <= has_four(occupied, color, 2);
                m_exp_y <= has_four(occupied, color, 1);
                m_full  <= &occupied;
                m_mover <= mover;
            end else if (m_busy) begin
                m_cnt <= m_cnt + 1;
                if (m_cnt == 43) m_busy <= 1'b0;
            end
            m_rv   <= m_pub;
            m_red  <= clear_game ? 1'b0 : (m_pub ? m_exp_r : m_red);
            m_yel  <= clear_game ? 1'b0 : (m_pub ? m_exp_y : m_yel);
            m_draw <= clear_game ? 1'b0 : (m_pub ? (m_full && !m_exp_r && !m_exp_y) : m_draw);
            m_go   <= clear_game ? 1'b0 : (m_pub ? (m_full || m_exp_r || m_exp_y) : m_go);
            m_sr   <= clear_score ? 4'd0 : ((m_pub && m_cr && m_sr != 4'd15) ? m_sr + 4'd1 : m_sr);
            m_sy   <= clear_score ? 4'd0 : ((m_pub && m_cy && m_sy != 4'd15) ? m_sy + 4'd1 : m_sy);
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic logic [13:0] dut_vec();
        return {busy, result_valid, red_win, yellow_win, draw, game_over, score_red, score_yellow};
    endfunction

    // Advance one cycle and compare every output against the model.
    task automatic cycle();
        @(negedge clk);
        if (chk_en)
            chk("cycle_outputs", int'(dut_vec()),
                int'({m_busy, m_rv, m_red, m_yel, m_draw, m_go, m_sr, m_sy}));
    endtask

    // Pulse start with a board, scramble inputs afterwards, run 60 cycles with optional side events.
    task automatic scan(input logic [41:0] o, input logic [41:0] c, input logic mv,
                        input int cg_at, input int cs_at, input int rs_at, input int st2_at,
                        output int lat, output int pulses);
        occupied = o; color = c; mover = mv; start = 1'b1;
        cycle();
        start = 1'b0; occupied = ~o; color = ~c; mover = ~mv;
        lat = -1; pulses = 0;
        for (int n = 1; n <= 60; n++) begin
            clear_game  = (n == cg_at);
            clear_score = (n == cs_at);
            reset       = (n == rs_at);
            start       = (n == st2_at) || (n == 43 && st2_at > 0);
            cycle();
            if (result_valid) begin
                if (lat < 0) lat = n;
                pulses++;
            end
        end
        clear_game = 1'b0; clear_score = 1'b0; reset = 1'b0; start = 1'b0;
    endtask

    logic [41:0] o_hr, c_hr, o_dy, c_dy, o_dbl, c_dbl, o_dr, c_dr;
    int lat, pulses;

    initial begin
        reset = 1'b1; start = 1'b0; mover = 1'b0; clear_game = 1'b0; clear_score = 1'b0;
        occupied = '0; color = '0;

        o_hr = '0; c_hr = '0;
        for (int k = 0; k < 4; k++) begin o_hr[k * 6] = 1'b1; c_hr[k * 6] = 1'b1; end
        o_dy = '0; c_dy = '0;
        for (int k = 0; k < 4; k++) o_dy[k * 6 + (3 - k)] = 1'b1;
        for (int k = 4; k < 7; k++) begin o_dy[k * 6] = 1'b1; c_dy[k * 6] = 1'b1; end
        o_dbl = '0; c_dbl = '0;
        for (int k = 0; k < 4; k++) begin o_dbl[k] = 1'b1; c_dbl[k] = 1'b1; end
        for (int k = 1; k < 5; k++) o_dbl[k * 6 + 5] = 1'b1;
        o_dr = '1; c_dr = '0;
        for (int cc = 0; cc < 7; cc++)
            for (int r = 0; r < 6; r++) c_dr[cc * 6 + r] = (((r + 2 * cc) % 4) < 2);

        chk("model_hr_red", int'(has_four(o_hr, c_hr, 2)), 1);
        chk("model_dy_yel", int'(has_four(o_dy, c_dy, 1)), 1);
        chk("model_draw_red", int'(has_four(o_dr, c_dr, 2)), 0);
        chk("model_draw_yel", int'(has_four(o_dr, c_dr, 1)), 0);

        cycle(); cycle();
        chk_en = 1'b1;
        reset = 1'b0;
        chk("reset_outputs", int'(dut_vec()), 0);
        cycle(); cycle(); cycle();
        chk("idle_busy", int'(busy), 0);

        scan(o_hr, c_hr, 1'b1, 0, 0, 0, 0, lat, pulses);
        chk("hr_latency", lat, 42);
        chk("hr_pulses", pulses, 1);
        chk("hr_flags", int'({red_win, yellow_win, draw, game_over}), 4'b1001);
        chk("hr_score_red", int'(score_red), 1);

        scan(o_dy, c_dy, 1'b0, 1, 0, 0, 0, lat, pulses);
        chk("dy_flags", int'({red_win, yellow_win, draw, game_over}), 4'b0101);
        chk("dy_scores", int'({score_red, score_yellow}), 8'h11);

        scan(o_dbl, c_dbl, 1'b1, 0, 0, 0, 0, lat, pulses);
        chk("dbl_flags", int'({red_win, yellow_win, draw, game_over}), 4'b1101);
        chk("dbl_scores", int'({score_red, score_yellow}), 8'h21);

        scan(o_dr, c_dr, 1'b0, 0, 0, 0, 0, lat, pulses);
        chk("draw_flags", int'({red_win, yellow_win, draw, game_over}), 4'b0011);
        chk("draw_scores", int'({score_red, score_yellow}), 8'h21);

        scan(o_hr, c_hr, 1'b1, 0, 0, 0, 10, lat, pulses);
        chk("restart_pulses", pulses, 1);
        chk("restart_latency", lat, 42);
        chk("restart_busy", int'(busy), 0);
        chk("restart_score_red", int'(score_red), 3);

        scan(o_hr, c_hr, 1'b1, 42, 0, 0, 0, lat, pulses);
        chk("clrgame_done_flags", int'({red_win, yellow_win, draw, game_over}), 0);
        chk("clrgame_done_score", int'(score_red), 4);

        scan(o_hr, c_hr, 1'b1, 0, 42, 0, 0, lat, pulses);
        chk("clrscore_done_scores", int'({score_red, score_yellow}), 0);
        chk("clrscore_done_red", int'(red_win), 1);

        scan(o_hr, c_hr, 1'b1, 0, 0, 21, 0, lat, pulses);
        chk("midreset_pulses", pulses, 0);
        chk("midreset_outputs", int'(dut_vec()), 0);

        for (int i = 0; i < 16; i++) scan(o_hr, c_hr, 1'b1, 0, 0, 0, 0, lat, pulses);
        chk("saturate_red", int'(score_red), 15);
        chk("saturate_yellow", int'(score_yellow), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/connect4_win_detector.md
# connect4_win_detector

Downstream consumer of the Connect-4 board-state block. After each accepted drop or pop it snapshots the 42-cell board, scans every cell for four-in-a-row in all four directions, and reports red/yellow wins, draw and game-over. It also keeps the per-colour match scores that feed the score display.

## Interface
- Parameters: none. Geometry constants come from `connect4_pkg`.
- `clk  in  1`: system clock.
- `reset  in  1`: synchronous, active-high. Clears all state and outputs.
- `start  in  1`: one-cycle strobe from the board block after a completed move.
- `mover  in  1`: colour that made the move (0 yellow, 1 red). Sampled with `start`.
- `occupied  in  42`: cell-occupied flags, index `col*6+row`, col 0..6 left→right, row 0 = bottom.
- `color  in  42`: cell colour, same indexing (0 yellow, 1 red). Ignored where `occupied`=0.
- `clear_game  in  1`: clears the result flags (new game). Scores are kept.
- `clear_score  in  1`: clears both scores.
- `busy  out  1`: scan in progress.
- `result_valid  out  1`: one-cycle pulse when a scan completes.
- `red_win  out  1`: sticky. Red four found on the last scan.
- `yellow_win  out  1`: sticky. Yellow four found on the last scan.
- `draw  out  1`: sticky. Board full with no four.
- `game_over  out  1`: sticky. OR of the three flags above.
- `score_red  out  4`: saturating match count for red.
- `score_yellow  out  4`: saturating match count for yellow.

## Operation
- FSM with three states.
  - IDLE → SCAN on `start` while not busy.
    - `occupied`, `color` and `mover` are latched into snapshot registers.
    - Anchor index is set to 0.
    - Accumulators `acc_r` and `acc_y` are cleared.
  - SCAN: one anchor cell per cycle, anchors 0..41.
    - For each anchor, evaluate lines of four in four directions: right (+c), up (+r), up-right (+c,+r), down-right (+c,−r).
    - A line counts only if it lies fully on the board.
    - A line counts only if all 4 cells are occupied and share one colour.
    - A hit sets `acc_r` or `acc_y`.
  - At anchor 41 → DONE.
  - DONE lasts one cycle.
    - `result_valid`=1.
    - Flags are registered: `red_win`=acc_r, `yellow_win`=acc_y, `draw`=all occupied & !acc_r & !acc_y, `game_over`=OR of the three.
    - Then → IDLE.
- Score update, in the DONE cycle:
  - Red only: `score_red` +1.
  - Yellow only: `score_yellow` +1.
  - Both colours (possible after a pop): only the latched `mover` colour scores.
  - Draw or no four: scores unchanged.
  - Scores saturate at 15.
- `start` while busy (SCAN or DONE) is ignored and not queued.
- `clear_game` takes effect in any state and clears all four flags.
  - If it coincides with the DONE cycle, clear wins: flags stay 0.
  - Scores still update in that case.
  - It does not abort a scan.
- `clear_score` coinciding with a score increment: clear wins and both scores become 0.
- `reset` mid-scan: the FSM returns to IDLE, no `result_valid` is produced, and all outputs are 0.

## Timing
- Reset values: `busy`=0, `result_valid`=0, all flags 0, scores 0.
- `start` is accepted at edge E0. `busy`=1 from E0 through E43.
- Anchors are evaluated after edges E1..E42.
- DONE is entered at E42. `result_valid` and the updated flags/scores are visible in the cycle following E42. Start-to-result latency is 42 cycles.
- `busy`=0 from E43. `start` is acceptable from the cycle after `result_valid`.
- Snapshot isolation: changes on `occupied`/`color` after E0 do not affect the result.

## Structure
- `connect4_pkg` holds:
  - COLS=7, ROWS=6, CELLS=42.
  - Colour constants YELLOW=0, RED=1.
  - Direction enum DIR_R, DIR_U, DIR_UR, DIR_DR.
  - Cell-index function `col*ROWS+row`.
- One combinational sub-module, `c4_line_check`.
  - Inputs: the snapshot and the anchor (col,row).
  - Outputs: `hit_red` and `hit_yellow`, ORed over the four directions, with bounds checks inside.
- The top module holds the FSM, anchor counter, snapshot, flags and scores.

## Test plan
- **Reset:** assert `reset` for 2 cycles → all outputs 0; `busy` stays 0 without `start`.
- **Horizontal red:** red at (0,0),(1,0),(2,0),(3,0), i.e. bits 0,6,12,18; pulse `start` → `result_valid` exactly 42 cycles later; `red_win`=1, `yellow_win`=0, `game_over`=1, `score_red`=1.
- **Down-right yellow:** yellow at (0,3),(1,2),(2,1),(3,0), plus unrelated reds → `yellow_win`=1, `score_yellow`=1.
- **Double four after pop:** vertical red in col 0 and horizontal yellow on row 5, `mover`=1 → both win flags 1; `score_red` +1, `score_yellow` unchanged.
- **Full-board draw:** all 42 occupied, red iff (row+2·col) mod 4 < 2 → `draw`=1, win flags 0, scores unchanged.
- **Robustness:**
  - Second `start` mid-scan → ignored, one `result_valid` only.
  - `clear_score` in the DONE cycle → both scores 0.
  - `reset` at anchor 20 → no `result_valid`, outputs 0.
